icache: RTL and testbench

- Direct-mapped, read-only instruction cache sitting directly upstream of fetch.
- Serves fetch's one-word requests with 1-cycle hit latency.
- Refills whole lines from the memory side over a burst interface.
- Honours fetch's flush by squashing responses for any request accepted before the flush.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_array.sv | 59 +++++
 rtl/icache.sv | 154 +++++++++++++++
 tb/tb_icache.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_pkg
// Summary  : shared address widths and controller state type for icache
// Revision : 1.0
// ============================================================================
package icache_pkg;

    localparam int ADDR_W       = 30;
    localparam int DEF_IDX_BITS = 6;
    localparam int DEF_OFF_BITS = 3;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MREQ = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic int tag_bits(input int idx_bits, input int off_bits);
        return ADDR_W - idx_bits - off_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
// Module   : icache_array
// Summary  : tag, valid and data storage for the direct-mapped icache
// Revision : 1.0
// ============================================================================
module icache_array
    import icache_pkg::*;
#(
    parameter int IDX_BITS = DEF_IDX_BITS,
    parameter int OFF_BITS = DEF_OFF_BITS,
    parameter int TAG_BITS = tag_bits(DEF_IDX_BITS, DEF_OFF_BITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] idx,
    input  logic [OFF_BITS-1:0] rd_off,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic                rd_valid,
    output logic [31:0]         rd_data,
    input  logic                data_we,
    input  logic [OFF_BITS-1:0] data_off,
    input  logic [31:0]         data_wdata,
    input  logic                line_we,
    input  logic [TAG_BITS-1:0] line_tag,
    input  logic                line_valid
);

    localparam int LINES = 1 << IDX_BITS;
    localparam int WORDS = 1 << OFF_BITS;

    logic [TAG_BITS-1:0] r_tag_mem  [LINES];
    logic [31:0]         r_data_mem [LINES*WORDS];
    logic [LINES-1:0]    r_valid_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_bits <= '0;
        end else if (line_we) begin
            r_valid_bits[idx] <= line_valid;
        end
    end

    // Tag and data carry no reset: a line is only trusted through its valid bit.
    always_ff @(posedge clk) begin
        if (line_we) begin
            r_tag_mem[idx] <= line_tag;
        end
        if (data_we) begin
            r_data_mem[{idx, data_off}] <= data_wdata;
        end
    end

    assign rd_tag   = r_tag_mem[idx];
    assign rd_valid = r_valid_bits[idx];
    assign rd_data  = r_data_mem[{idx, rd_off}];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Summary  : direct-mapped read-only instruction cache, 1-cycle hit, burst refill
// Revision : 1.0
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int IDX_BITS = DEF_IDX_BITS,
    parameter int OFF_BITS = DEF_OFF_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_ic_req,
    input  logic [ADDR_W-1:0]          fetch_ic_addr,
    input  logic                       fetch_ic_flush,
    output logic                       icache_ready,
    output logic                       icache_valid,
    output logic                       icache_error,
    output logic [31:0]                icache_data,
    output logic                       ic_mem_req,
    output logic [ADDR_W-OFF_BITS-1:0] ic_mem_addr,
    input  logic                       mem_ic_ready,
    input  logic                       mem_ic_valid,
    input  logic                       mem_ic_error,
    input  logic [31:0]                mem_ic_data
);

    localparam int TAG_BITS = tag_bits(IDX_BITS, OFF_BITS);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_pending;
    logic                r_squashed;
    logic                r_mem_req;
    logic                r_err;
    logic [OFF_BITS-1:0] r_beat;
    logic [31:0]         r_word;

    logic [OFF_BITS-1:0] w_off;
    logic [IDX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0] w_tag;
    logic [TAG_BITS-1:0] w_rd_tag;
    logic                w_rd_valid;
    logic [31:0]         w_rd_data;
    logic                w_hit;
    logic                w_miss;
    logic                w_accept;
    logic                w_beat;
    logic                w_last;
    logic                w_err_acc;

    assign w_off = r_addr[OFF_BITS-1:0];
    assign w_idx = r_addr[OFF_BITS +: IDX_BITS];
    assign w_tag = r_addr[ADDR_W-1 -: TAG_BITS];

    icache_array #(
        .IDX_BITS (IDX_BITS),
        .OFF_BITS (OFF_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .idx        (w_idx),
        .rd_off     (w_off),
        .rd_tag     (w_rd_tag),
        .rd_valid   (w_rd_valid),
        .rd_data    (w_rd_data),
        .data_we    (w_beat),
        .data_off   (r_beat),
        .data_wdata (mem_ic_data),
        .line_we    (w_last),
        .line_tag   (w_tag),
        .line_valid (~w_err_acc)
    );

    // The lookup runs the cycle after accept, against the registered address.
    assign w_hit     = w_rd_valid && (w_rd_tag == w_tag);
    assign w_miss    = (r_state == RUN) && r_pending && !w_hit;
    assign w_accept  = fetch_ic_req && icache_ready;
    assign w_beat    = !rst && (r_state == FILL) && mem_ic_valid;
    assign w_last    = w_beat && (&r_beat);
    assign w_err_acc = r_err | mem_ic_error;

    assign icache_ready = (r_state == RUN) && !w_miss;
    assign icache_valid = ((r_state == RUN) && r_pending && w_hit) ||
                          ((r_state == RESP) && !r_squashed);
    assign icache_error = (r_state == RESP) && r_err;
    assign icache_data  = (r_state == RESP) ? r_word : w_rd_data;
    assign ic_mem_req   = r_mem_req;
    assign ic_mem_addr  = r_addr[ADDR_W-1:OFF_BITS];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr <= fetch_ic_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_pending  <= 1'b0;
            r_squashed <= 1'b0;
            r_mem_req  <= 1'b0;
            r_err      <= 1'b0;
            r_beat     <= '0;
        end else begin
            r_pending <= w_accept;
            case (r_state)
                RUN: begin
                    // A flush landing on the miss cycle drops the miss outright.
                    if (w_miss && !fetch_ic_flush) begin
                        r_state   <= MREQ;
                        r_mem_req <= 1'b1;
                    end
                end
                MREQ: begin
                    if (fetch_ic_flush) begin
                        r_squashed <= 1'b1;
                    end
                    if (mem_ic_ready) begin
                        r_mem_req <= 1'b0;
                        r_beat    <= '0;
                        r_err     <= 1'b0;
                        r_state   <= FILL;
                    end
                end
                FILL: begin
                    if (fetch_ic_flush) begin
                        r_squashed <= 1'b1;
                    end
                    if (mem_ic_valid) begin
                        r_beat <= r_beat + 1'b1;
                        r_err  <= w_err_acc;
                        if (r_beat == w_off) begin
                            r_word <= mem_ic_data;
                        end
                        if (&r_beat) begin
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    r_state    <= RUN;
                    r_squashed <= 1'b0;
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache
// Summary  : self-checking bench for icache with a randomized memory responder
// Revision : 1.0
// ============================================================================
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_ic_req;
    logic [29:0] fetch_ic_addr;
    logic        fetch_ic_flush;
    logic        icache_ready;
    logic        icache_valid;
    logic        icache_error;
    logic [31:0] icache_data;
    logic        ic_mem_req;
    logic [26:0] ic_mem_addr;
    logic        mem_ic_ready;
    logic        mem_ic_valid;
    logic        mem_ic_error;
    logic [31:0] mem_ic_data;

    always #5 clk = ~clk;

    icache dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_ic_req   (fetch_ic_req),
        .fetch_ic_addr  (fetch_ic_addr),
        .fetch_ic_flush (fetch_ic_flush),
        .icache_ready   (icache_ready),
        .icache_valid   (icache_valid),
        .icache_error   (icache_error),
        .icache_data    (icache_data),
        .ic_mem_req     (ic_mem_req),
        .ic_mem_addr    (ic_mem_addr),
        .mem_ic_ready   (mem_ic_ready),
        .mem_ic_valid   (mem_ic_valid),
        .mem_ic_error   (mem_ic_error),
        .mem_ic_data    (mem_ic_data)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // memory responder state
    bit          err_en = 1'b0;
    logic [26:0] err_line = '0;
    int          err_beat = 0;
    int          mbeats = 0;
    int          fills = 0;
    int          last_beat_cyc = -1;
    logic [26:0] last_fill_line = '0;

    function automatic logic [31:0] mem_word(input logic [26:0] ln, input int w);
        logic [2:0]  w3;
        logic [31:0] r;
        w3 = w[2:0];
        if (ln == 27'h8) r = 32'hA0 + {29'd0, w3};
        else             r = {2'b10, ln, w3};
        return r;
    endfunction

    initial begin
        int          phase;
        int          delay;
        logic [26:0] ln;
        phase = 0; delay = 0; ln = '0;
        mem_ic_ready = 1'b0; mem_ic_valid = 1'b0; mem_ic_error = 1'b0; mem_ic_data = '0;
        forever begin
            @(posedge clk); #2;
            mem_ic_ready = 1'b0; mem_ic_valid = 1'b0; mem_ic_error = 1'b0; mem_ic_data = '0;
            if (rst) begin
                phase = 0;
                mbeats = 0;
            end else begin
                if (phase == 0 && ic_mem_req) begin
                    ln = ic_mem_addr;
                    last_fill_line = ln;
                    delay = $urandom_range(0, 2);
                    mbeats = 0;
                    fills++;
                    phase = 1;
                end
                if (phase == 1) begin
                    if (delay == 0) begin
                        mem_ic_ready = 1'b1;
                        phase = 2;
                    end else begin
                        delay--;
                    end
                end else if (phase == 2) begin
                    if ($urandom_range(0, 3) != 0) begin
                        mem_ic_valid = 1'b1;
                        mem_ic_data  = mem_word(ln, mbeats);
                        mem_ic_error = err_en && (ln == err_line) && (mbeats == err_beat);
                        mbeats++;
                        if (mbeats == 8) begin
                            last_beat_cyc = cyc;
                            phase = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && !icache_ready; i++) tick();
    endtask

    // Issues one request and follows it until a response or a squashed return to RUN.
    task automatic do_req(input logic [29:0] a, input int flush_beat,
                          output bit got_v, output logic [31:0] got_d, output bit got_e,
                          output int lat, output int vcyc, output int nfill,
                          output bit rdy_low, output bit tmo);
        int start;
        int f0;
        bit fl_done;
        got_v = 0; got_d = '0; got_e = 0; lat = -1; vcyc = -1;
        rdy_low = 1; tmo = 0; fl_done = 0;
        wait_ready();
        f0 = fills;
        fetch_ic_req = 1'b1; fetch_ic_addr = a; start = cyc;
        tick();
        fetch_ic_req = 1'b0;
        for (int i = 0; i < 300; i++) begin
            fetch_ic_flush = 1'b0;
            if (icache_valid) begin
                got_v = 1; got_d = icache_data; got_e = icache_error;
                lat = cyc - start; vcyc = cyc;
                break;
            end
            if (icache_ready && (cyc - start) > 1) break;
            if (icache_ready) rdy_low = 0;
            if (flush_beat > 0 && !fl_done && fills > f0 && mbeats >= flush_beat) begin
                fetch_ic_flush = 1'b1;
                fl_done = 1;
            end
            if (i == 299) tmo = 1;
            tick();
        end
        fetch_ic_flush = 1'b0;
        nfill = fills - f0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (icache_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", icache_valid); end
        n_checks++; if (icache_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b want=0", icache_error); end
        n_checks++; if (ic_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b want=0", ic_mem_req); end
        n_checks++; if (icache_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", icache_ready); end
    endtask

    task automatic test_cold_miss();
        bit v, e, rl, to; logic [31:0] d; int lat, vc, nf;
        do_req(30'h40, 0, v, d, e, lat, vc, nf, rl, to);
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL cold_valid got=%b want=1", v); end
        n_checks++; if (d !== 32'hA0) begin n_fail++; $display("FAIL cold_data got=%h want=000000a0", d); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL cold_error got=%b want=0", e); end
        n_checks++; if (nf !== 1) begin n_fail++; $display("FAIL cold_fills got=%0d want=1", nf); end
        n_checks++; if (last_fill_line !== 27'h8) begin n_fail++; $display("FAIL cold_mem_addr got=%h want=8", last_fill_line); end
        n_checks++; if (rl !== 1'b1) begin n_fail++; $display("FAIL cold_ready_low got=%b want=1", rl); end
        n_checks++; if (vc - last_beat_cyc !== 1) begin n_fail++; $display("FAIL cold_resp_timing got=%0d want=1", vc - last_beat_cyc); end
    endtask

    task automatic test_stream();
        int f0;
        bit req_seen;
        logic [31:0] exp_d;
        wait_ready();
        f0 = fills; req_seen = 0;
        for (int k = 0; k <= 8; k++) begin
            if (ic_mem_req) req_seen = 1;
            if (k > 0) begin
                exp_d = 32'hA0 + k - 1;
                n_checks++;
                if ({icache_valid, icache_data} !== {1'b1, exp_d}) begin
                    n_fail++;
                    $display("FAIL stream_hit%0d got v=%b d=%h want v=1 d=%h", k - 1, icache_valid, icache_data, exp_d);
                end
            end
            if (k < 8) begin
                fetch_ic_req = 1'b1; fetch_ic_addr = 30'h40 + k;
            end else begin
                fetch_ic_req = 1'b0;
            end
            tick();
        end
        n_checks++; if ((fills - f0) !== 0 || req_seen) begin n_fail++; $display("FAIL stream_no_fill got fills=%0d req=%b want 0", fills - f0, req_seen); end
    endtask

    task automatic test_conflict();
        bit v, e, rl, to; logic [31:0] d; int lat, vc, nf;
        do_req(30'h240, 0, v, d, e, lat, vc, nf, rl, to);
        n_checks++; if (nf !== 1) begin n_fail++; $display("FAIL conflict_fill got=%0d want=1", nf); end
        n_checks++; if (last_fill_line !== 27'h48) begin n_fail++; $display("FAIL conflict_addr got=%h want=48", last_fill_line); end
        n_checks++; if ({v, d} !== {1'b1, mem_word(27'h48, 0)}) begin n_fail++; $display("FAIL conflict_data got v=%b d=%h want v=1 d=%h", v, d, mem_word(27'h48, 0)); end
        do_req(30'h40, 0, v, d, e, lat, vc, nf, rl, to);
        n_checks++; if (nf !== 1) begin n_fail++; $display("FAIL conflict_evict got fills=%0d want=1", nf); end
        n_checks++; if ({v, d} !== {1'b1, 32'hA0}) begin n_fail++; $display("FAIL conflict_refill got v=%b d=%h want v=1 d=000000a0", v, d); end
    endtask

    task automatic test_flush();
        bit v, e, rl, to; logic [31:0] d; int lat, vc, nf;
        do_req(30'h243, 3, v, d, e, lat, vc, nf, rl, to);
        n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL flush_squash got valid=%b want=0", v); end
        n_checks++; if (nf !== 1 || to) begin n_fail++; $display("FAIL flush_fill got fills=%0d timeout=%b want 1/0", nf, to); end
        do_req(30'h243, 0, v, d, e, lat, vc, nf, rl, to);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL flush_rehit_latency got=%0d want=1", lat); end
        n_checks++; if ({v, d} !== {1'b1, mem_word(27'h48, 3)}) begin n_fail++; $display("FAIL flush_rehit_data got v=%b d=%h want v=1 d=%h", v, d, mem_word(27'h48, 3)); end
        n_checks++; if (nf !== 0) begin n_fail++; $display("FAIL flush_rehit_fill got=%0d want=0", nf); end
    endtask

    task automatic test_bus_error();
        bit v, e, rl, to; logic [31:0] d; int lat, vc, nf;
        err_en = 1'b1; err_line = 27'h20; err_beat = 5;
        do_req(30'h105, 0, v, d, e, lat, vc, nf, rl, to);
        n_checks++; if ({v, e} !== 2'b11) begin n_fail++; $display("FAIL buserr_resp got v=%b e=%b want 1/1", v, e); end
        n_checks++; if (d !== mem_word(27'h20, 5)) begin n_fail++; $display("FAIL buserr_data got=%h want=%h", d, mem_word(27'h20, 5)); end
        n_checks++; if (nf !== 1) begin n_fail++; $display("FAIL buserr_fill got=%0d want=1", nf); end
        do_req(30'h105, 0, v, d, e, lat, vc, nf, rl, to);
        n_checks++; if (nf !== 1) begin n_fail++; $display("FAIL buserr_remiss got fills=%0d want=1", nf); end
        n_checks++; if ({v, e} !== 2'b11) begin n_fail++; $display("FAIL buserr_again got v=%b e=%b want 1/1", v, e); end
        err_en = 1'b0;
        do_req(30'h105, 0, v, d, e, lat, vc, nf, rl, to);
        n_checks++; if ({v, e, nf} !== {1'b1, 1'b0, 32'd1}) begin n_fail++; $display("FAIL buserr_clean got v=%b e=%b fills=%0d want 1/0/1", v, e, nf); end
    endtask

    task automatic test_reset_mid_fill();
        bit v, e, rl, to; logic [31:0] d; int lat, vc, nf; int f0; bit reached;
        wait_ready();
        f0 = fills; reached = 0;
        fetch_ic_req = 1'b1; fetch_ic_addr = 30'h300;
        tick();
        fetch_ic_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (fills > f0 && mbeats >= 2) begin reached = 1; break; end
            tick();
        end
        n_checks++; if (!reached) begin n_fail++; $display("FAIL rstfill_reach got=0 want=1"); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (icache_ready !== 1'b1) begin n_fail++; $display("FAIL rstfill_ready got=%b want=1", icache_ready); end
        n_checks++; if (ic_mem_req !== 1'b0) begin n_fail++; $display("FAIL rstfill_mem_req got=%b want=0", ic_mem_req); end
        n_checks++; if (icache_valid !== 1'b0) begin n_fail++; $display("FAIL rstfill_valid got=%b want=0", icache_valid); end
        do_req(30'h300, 0, v, d, e, lat, vc, nf, rl, to);
        n_checks++; if ({v, nf} !== {1'b1, 32'd1} || d !== mem_word(27'h60, 0)) begin n_fail++; $display("FAIL rstfill_remiss got v=%b fills=%0d d=%h want 1/1/%h", v, nf, d, mem_word(27'h60, 0)); end
        do_req(30'h40, 0, v, d, e, lat, vc, nf, rl, to);
        n_checks++; if ({v, nf} !== {1'b1, 32'd1} || d !== 32'hA0) begin n_fail++; $display("FAIL rstfill_cleared got v=%b fills=%0d d=%h want 1/1/a0", v, nf, d); end
    endtask

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    task automatic test_random();
        exp_t        q[$];
        exp_t        ex;
        bit          m_valid[64];
        logic [20:0] m_tag[64];
        logic [26:0] pool[5];
        logic [26:0] ln;
        logic [2:0]  off;
        logic [5:0]  idx;
        int          f0, nmiss;
        bit          hit;
        pool[0] = 27'h8; pool[1] = 27'h9; pool[2] = 27'h48; pool[3] = 27'h49; pool[4] = 27'h88;
        for (int i = 0; i < 64; i++) begin m_valid[i] = 0; m_tag[i] = '0; end
        do_reset();
        f0 = fills; nmiss = 0;
        for (int i = 0; i < 500; i++) begin
            if (icache_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_unexpected got valid d=%h want none", icache_data);
                end else begin
                    ex = q.pop_front();
                    if ({icache_error, icache_data} !== {1'b0, ex.d} || (ex.due >= 0 && cyc != ex.due)) begin
                        n_fail++;
                        $display("FAIL rnd_resp got e=%b d=%h cyc=%0d want e=0 d=%h due=%0d", icache_error, icache_data, cyc, ex.d, ex.due);
                    end
                end
            end
            if (i < 400 && icache_ready && $urandom_range(0, 3) != 0) begin
                ln  = pool[$urandom_range(0, 4)];
                off = 3'($urandom_range(0, 7));
                idx = ln[5:0];
                hit = m_valid[idx] && (m_tag[idx] == ln[26:6]);
                if (!hit) begin
                    m_valid[idx] = 1; m_tag[idx] = ln[26:6]; nmiss++;
                end
                ex.d = mem_word(ln, {29'd0, off});
                ex.due = hit ? cyc + 1 : -1;
                q.push_back(ex);
                fetch_ic_req = 1'b1; fetch_ic_addr = {ln, off};
            end else begin
                fetch_ic_req = 1'b0;
            end
            tick();
        end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got pending=%0d want=0", q.size()); end
        n_checks++; if ((fills - f0) != nmiss) begin n_fail++; $display("FAIL rnd_fills got=%0d want=%0d", fills - f0, nmiss); end
    endtask

    initial begin
        rst = 1'b1;
        fetch_ic_req = 1'b0; fetch_ic_addr = '0; fetch_ic_flush = 1'b0;
        test_reset();
        test_cold_miss();
        test_stream();
        test_conflict();
        test_flush();
        test_bus_error();
        test_reset_mid_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
